// File: rtl/load_extend_unit_if.sv
// -----------------------------------------------------------------------------
// load_extend_unit_if
//   Avalon-style read bus between the load/extend unit (master) and the data
//   memory (slave).
//
//   mem_address      master -> slave  word-aligned byte address
//   mem_read         master -> slave  read request
//   mem_byteenable   master -> slave  all ones while mem_read=1, else zero
//   mem_waitrequest  slave -> master  stall; read completes when low with mem_read
//   mem_readdata     slave -> master  read data, valid in the completing cycle
// -----------------------------------------------------------------------------
interface load_extend_unit_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [31:0]           mem_address;
  logic                  mem_read;
  logic [BYTES-1:0]      mem_byteenable;
  logic                  mem_waitrequest;
  logic [DATA_WIDTH-1:0] mem_readdata;

  modport master (
    output mem_address,
    output mem_read,
    output mem_byteenable,
    input  mem_waitrequest,
    input  mem_readdata
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    input  mem_byteenable,
    output mem_waitrequest,
    output mem_readdata
  );
endinterface

// File: rtl/load_extend_unit.sv
// -----------------------------------------------------------------------------
// load_extend_unit
//   Sequential load-data path. On an accepted start it issues one word read,
//   then extracts/aligns/extends the addressed byte or half (LB/LBU/LH/LHU),
//   passes the whole word (LW), or merges a partial word into the old rt value
//   (LWL/LWR). Misaligned or invalid requests finish without a bus access and
//   flag addr_error. Also produces the sign/zero-extended I-type immediate.
//
//   clk, reset      clock, synchronous active-high reset
//   start           accept a request (ignored while busy)
//   funct           000 LB,001 LH,010 LWL,011 LW,100 LBU,101 LHU,110 LWR,111 invalid
//   addr            byte address of the load
//   rt_old          old rt value, merge source for LWL/LWR (sampled with start)
//   immediate       instruction immediate
//   imm_zero_ext    1: zero-extend immediate, 0: sign-extend
//   extended_imm    extended immediate (combinational)
//   bus             read bus (master side)
//   busy            high in every state except IDLE
//   done            one-cycle pulse, result/addr_error valid
//   result          loaded value, held until the next successful load
//   addr_error      with done: misaligned address or invalid funct
// -----------------------------------------------------------------------------
module load_extend_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] rt_old,
  input  logic [IMM_WIDTH-1:0]  immediate,
  input  logic                  imm_zero_ext,
  output logic [DATA_WIDTH-1:0] extended_imm,
  load_extend_unit_if.master    bus,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  addr_error
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(BYTES);

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LWL = 3'b010;
  localparam logic [2:0] F_LW  = 3'b011;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;
  localparam logic [2:0] F_LWR = 3'b110;
  localparam logic [2:0] F_INV = 3'b111;

  localparam logic [DATA_WIDTH-1:0] ONES = {DATA_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            funct_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] rt_q;
  logic [DATA_WIDTH-1:0] result_q;

  logic                  accept;
  logic                  complete;
  logic                  req_error;
  logic [DATA_WIDTH-1:0] load_value;

  // Immediate extension is purely combinational.
  assign extended_imm = {{(DATA_WIDTH-IMM_WIDTH){~imm_zero_ext & immediate[IMM_WIDTH-1]}},
                         immediate};

  // Request check on the live inputs, so an error is known in the accept cycle.
  always_comb begin
    req_error = 1'b0;
    case (funct)
      F_INV:        req_error = 1'b1;
      F_LH, F_LHU:  req_error = addr[0];
      F_LW:         req_error = (addr[LANE_W-1:0] != '0);
      default:      req_error = 1'b0;
    endcase
  end

  // Split the read word into little-endian byte lanes.
  logic [7:0] rd_bytes [BYTES];
  genvar gi;
  for (gi = 0; gi < BYTES; gi++) begin : g_lanes
    assign rd_bytes[gi] = bus.mem_readdata[8*gi +: 8];
  end

  logic [LANE_W-1:0] lane;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [LANE_W+2:0] sh_right;
  logic [LANE_W+2:0] sh_left;

  assign lane     = addr_q[LANE_W-1:0];
  assign sel_byte = rd_bytes[lane];
  // Halves are always even-aligned when they reach the bus, so forcing the
  // lane LSB keeps both indices in range without changing the result.
  assign sel_half = {rd_bytes[lane | LANE_W'(1)], rd_bytes[lane & ~LANE_W'(1)]};
  // 8*k and 8*(BYTES-1-k); ~k equals BYTES-1-k because BYTES is a power of two.
  assign sh_right = {lane, 3'b000};
  assign sh_left  = {~lane, 3'b000};

  always_comb begin
    load_value = bus.mem_readdata;
    case (funct_q)
      F_LB:    load_value = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
      F_LBU:   load_value = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
      F_LH:    load_value = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
      F_LHU:   load_value = {{(DATA_WIDTH-16){1'b0}}, sel_half};
      F_LWL:   load_value = (bus.mem_readdata << sh_left) | (rt_q & ~(ONES << sh_left));
      F_LWR:   load_value = (bus.mem_readdata >> sh_right) | (rt_q & ~(ONES >> sh_right));
      default: load_value = bus.mem_readdata;
    endcase
  end

  // Next-state and outputs.
  always_comb begin
    state_d             = state_q;
    accept              = 1'b0;
    complete            = 1'b0;
    busy                = 1'b1;
    done                = 1'b0;
    addr_error          = 1'b0;
    bus.mem_read        = 1'b0;
    bus.mem_byteenable  = '0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept  = 1'b1;
          state_d = req_error ? S_ERR : S_READ;
        end
      end
      S_READ: begin
        bus.mem_read       = 1'b1;
        bus.mem_byteenable = '1;
        if (!bus.mem_waitrequest) begin
          complete = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done       = 1'b1;
        addr_error = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_address = {addr_q[31:LANE_W], {LANE_W{1'b0}}};
  assign result          = result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      funct_q  <= '0;
      addr_q   <= '0;
      rt_q     <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct_q <= funct;
        addr_q  <= addr;
        rt_q    <= rt_old;
      end
      if (complete) begin
        result_q <= load_value;
      end
    end
  end
endmodule

// File: tb/tb_load_extend_unit.sv
// -----------------------------------------------------------------------------
// tb_load_extend_unit
//   Drives a 32-bit and a 64-bit instance with a small bus responder. Each load
//   pushes its expected outcome to a per-instance queue; a monitor pops and
//   compares result, addr_error, latency, read-cycle count and bus address.
// -----------------------------------------------------------------------------
module tb_load_extend_unit;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LWL = 3'b010;
  localparam logic [2:0] LW  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWR = 3'b110;
  localparam logic [2:0] INV = 3'b111;

  typedef struct {
    logic [63:0] res;
    logic        err;
    int          start_cyc;
    int          lat;
    int          reads;
    logic [31:0] maddr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start32, start64;
  logic [2:0]  funct;
  logic [31:0] addr;
  logic [63:0] rt_old;
  logic [15:0] immediate;
  logic        imm_zero_ext;
  logic [31:0] ext32, res32;
  logic [63:0] ext64, res64;
  logic        busy32, done32, err32;
  logic        busy64, done64, err64;

  int          stall_cfg;
  logic [63:0] rdata_cfg;
  int          stall_cnt [2];
  int          rd_cnt [2];
  logic [63:0] last_res [2];
  int          cyc;
  int          n_tests;
  int          n_fail;
  exp_t        sb32[$];
  exp_t        sb64[$];

  load_extend_unit_if #(.DATA_WIDTH(32)) bus32 ();
  load_extend_unit_if #(.DATA_WIDTH(64)) bus64 ();

  load_extend_unit #(.DATA_WIDTH(32), .IMM_WIDTH(16)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .funct(funct), .addr(addr),
    .rt_old(rt_old[31:0]), .immediate(immediate), .imm_zero_ext(imm_zero_ext),
    .extended_imm(ext32), .bus(bus32), .busy(busy32), .done(done32),
    .result(res32), .addr_error(err32)
  );

  load_extend_unit #(.DATA_WIDTH(64), .IMM_WIDTH(16)) u_dut64 (
    .clk(clk), .reset(reset), .start(start64), .funct(funct), .addr(addr),
    .rt_old(rt_old), .immediate(immediate), .imm_zero_ext(imm_zero_ext),
    .extended_imm(ext64), .bus(bus64), .busy(busy64), .done(done64),
    .result(res64), .addr_error(err64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? sb32.size() : sb64.size();
  endfunction

  // Memory model: hold waitrequest for stall_cfg cycles, then return rdata_cfg.
  initial begin
    bus32.mem_waitrequest = 1'b0;
    bus32.mem_readdata    = '0;
    bus64.mem_waitrequest = 1'b0;
    bus64.mem_readdata    = '0;
    stall_cnt[0] = 0;
    stall_cnt[1] = 0;
    forever begin
      @(negedge clk);
      if (bus32.mem_read) begin
        if (stall_cnt[0] < stall_cfg) begin
          bus32.mem_waitrequest = 1'b1;
          stall_cnt[0]++;
        end else begin
          bus32.mem_waitrequest = 1'b0;
          bus32.mem_readdata    = rdata_cfg[31:0];
        end
      end else begin
        bus32.mem_waitrequest = 1'b0;
        stall_cnt[0] = 0;
      end
      if (bus64.mem_read) begin
        if (stall_cnt[1] < stall_cfg) begin
          bus64.mem_waitrequest = 1'b1;
          stall_cnt[1]++;
        end else begin
          bus64.mem_waitrequest = 1'b0;
          bus64.mem_readdata    = rdata_cfg;
        end
      end else begin
        bus64.mem_waitrequest = 1'b0;
        stall_cnt[1] = 0;
      end
    end
  end

  task automatic observe(input int d, input logic dn, input logic ae, input logic [63:0] res,
                         input logic rd, input logic [31:0] ma, input logic be_full);
    exp_t e;
    if (rd) begin
      if (qsize(d) == 0) begin
        check("spurious_read", 64'(rd), 64'd0);
      end else if (rd_cnt[d] == 0) begin
        e = (d == 0) ? sb32[0] : sb64[0];
        check("mem_address", 64'(ma), 64'(e.maddr));
        check("byteenable", 64'(be_full), 64'd1);
      end
      rd_cnt[d]++;
    end
    if (dn) begin
      if (qsize(d) == 0) begin
        check("spurious_done", 64'(dn), 64'd0);
      end else begin
        if (d == 0) e = sb32.pop_front();
        else        e = sb64.pop_front();
        check("result", res, e.res);
        check("addr_error", 64'(ae), 64'(e.err));
        check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
        check("read_cycles", 64'(rd_cnt[d]), 64'(e.reads));
      end
      rd_cnt[d] = 0;
    end
  endtask

  initial begin
    rd_cnt[0] = 0;
    rd_cnt[1] = 0;
    forever begin
      @(negedge clk);
      observe(0, done32, err32, {32'd0, res32}, bus32.mem_read, bus32.mem_address,
              &bus32.mem_byteenable);
      observe(1, done64, err64, res64, bus64.mem_read, bus64.mem_address,
              &bus64.mem_byteenable);
    end
  end

  task automatic do_load(input int d, input logic [2:0] f, input logic [31:0] a,
                         input logic [63:0] rt, input logic [63:0] dat, input int stalls,
                         input logic [63:0] exp_res, input logic exp_err, input bit poke);
    exp_t e;
    @(negedge clk);
    stall_cfg = stalls;
    rdata_cfg = dat;
    funct     = f;
    addr      = a;
    rt_old    = rt;
    e.res       = exp_err ? last_res[d] : exp_res;
    e.err       = exp_err;
    e.start_cyc = cyc;
    e.lat       = exp_err ? 1 : 2 + stalls;
    e.reads     = exp_err ? 0 : stalls + 1;
    e.maddr     = a & ~((d == 0) ? 32'h3 : 32'h7);
    if (!exp_err) last_res[d] = exp_res;
    if (d == 0) sb32.push_back(e);
    else        sb64.push_back(e);
    $display("[TB] dut%0d funct=%b addr=%h rt=%h data=%h stalls=%0d -> expect result=%h addr_error=%b",
             d == 0 ? 32 : 64, f, a, rt, dat, stalls, e.res, exp_err);
    if (d == 0) start32 = 1'b1;
    else        start64 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    start64 = 1'b0;
    if (poke) begin
      // Unit is in READ now; this request must be dropped.
      funct = INV;
      if (d == 0) start32 = 1'b1;
      else        start64 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      start64 = 1'b0;
    end
    #1;
    for (int i = 0; i < 60; i++) begin
      if (qsize(d) == 0) break;
      @(negedge clk);
      #1;
    end
    if (qsize(d) != 0) begin
      check("done_timeout", 64'(qsize(d)), 64'd0);
      sb32.delete();
      sb64.delete();
    end
  endtask

  initial begin
    exp_t e;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    start32 = 1'b0;
    start64 = 1'b0;
    funct = LB;
    addr = '0;
    rt_old = '0;
    immediate = '0;
    imm_zero_ext = 1'b0;
    stall_cfg = 0;
    rdata_cfg = '0;
    last_res[0] = '0;
    last_res[1] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_done", 64'(done32), 64'd0);
    check("rst_mem_read", 64'(bus32.mem_read), 64'd0);
    check("rst_byteenable", 64'(bus32.mem_byteenable), 64'd0);
    check("rst_mem_address", 64'(bus32.mem_address), 64'd0);
    check("rst_result", 64'(res32), 64'd0);
    check("rst_addr_error", 64'(err32), 64'd0);
    check("rst_busy64", 64'(busy64), 64'd0);
    check("rst_result64", res64, 64'd0);

    immediate = 16'hffff; imm_zero_ext = 1'b0; #1;
    check("ext_imm_ffff", 64'(ext32), 64'h0000_0000_ffff_ffff);
    check("ext_imm64_ffff", ext64, 64'hffff_ffff_ffff_ffff);
    immediate = 16'hc84d; imm_zero_ext = 1'b1; #1;
    check("ext_imm_c84d_z", 64'(ext32), 64'h0000_0000_0000_c84d);
    check("ext_imm64_c84d_z", ext64, 64'h0000_0000_0000_c84d);
    immediate = 16'h7aec; imm_zero_ext = 1'b0; #1;
    check("ext_imm_7aec", 64'(ext32), 64'h0000_0000_0000_7aec);
    immediate = 16'h8000; imm_zero_ext = 1'b0; #1;
    check("ext_imm64_8000", ext64, 64'hffff_ffff_ffff_8000);

    // 32-bit loads: d, funct, addr, rt, data, stalls, expected, err, poke
    do_load(0, LB,  32'h1003, 64'h0, 64'h80ff_7f00, 0, 64'hffff_ff80, 1'b0, 1'b0);
    do_load(0, LBU, 32'h1003, 64'h0, 64'h80ff_7f00, 0, 64'h0000_0080, 1'b0, 1'b0);
    do_load(0, LB,  32'h1001, 64'h0, 64'h80ff_7f00, 0, 64'h0000_007f, 1'b0, 1'b0);
    do_load(0, LBU, 32'h1002, 64'h0, 64'h80ff_7f00, 1, 64'h0000_00ff, 1'b0, 1'b0);
    do_load(0, LH,  32'h2002, 64'h0, 64'hc84d_1234, 3, 64'hffff_c84d, 1'b0, 1'b0);
    do_load(0, LHU, 32'h2002, 64'h0, 64'hc84d_1234, 3, 64'h0000_c84d, 1'b0, 1'b0);
    do_load(0, LH,  32'h2000, 64'h0, 64'hc84d_1234, 0, 64'h0000_1234, 1'b0, 1'b0);
    do_load(0, LW,  32'h4000, 64'h0, 64'hdead_beef, 1, 64'hdead_beef, 1'b0, 1'b1);
    // LWL k=1: (D<<16) | (R & 0000ffff); k=0: (D<<24) | (R & 00ffffff)
    do_load(0, LWL, 32'h3001, 64'haabb_ccdd, 64'h4433_2211, 0, 64'h2211_ccdd, 1'b0, 1'b0);
    do_load(0, LWL, 32'h3000, 64'haabb_ccdd, 64'h4433_2211, 0, 64'h11bb_ccdd, 1'b0, 1'b0);
    // LWR k=1: (D>>8) | (R & ff000000); k=3: (D>>24) | (R & ffffff00)
    do_load(0, LWR, 32'h3001, 64'haabb_ccdd, 64'h4433_2211, 0, 64'haa44_3322, 1'b0, 1'b0);
    do_load(0, LWR, 32'h3003, 64'haabb_ccdd, 64'h4433_2211, 2, 64'haabb_cc44, 1'b0, 1'b0);
    // Rejected requests keep the previous result.
    do_load(0, LH,  32'h2001, 64'h0, 64'hc84d_1234, 0, 64'h0, 1'b1, 1'b0);
    do_load(0, INV, 32'h1000, 64'h0, 64'hc84d_1234, 0, 64'h0, 1'b1, 1'b0);
    do_load(0, LW,  32'h3002, 64'h0, 64'hc84d_1234, 0, 64'h0, 1'b1, 1'b0);
    do_load(0, LHU, 32'h2003, 64'h0, 64'hc84d_1234, 0, 64'h0, 1'b1, 1'b0);
    do_load(0, LB,  32'h1000, 64'h0, 64'h80ff_7f00, 0, 64'h0000_0000, 1'b0, 1'b0);

    // 64-bit instance
    do_load(1, LW,  32'h0008, 64'h0, 64'h0123_4567_89ab_cdef, 0, 64'h0123_4567_89ab_cdef, 1'b0, 1'b0);
    do_load(1, LB,  32'h000f, 64'h0, 64'h0123_4567_89ab_cdef, 0, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
    do_load(1, LH,  32'h000e, 64'h0, 64'h0123_4567_89ab_cdef, 1, 64'h0000_0000_0000_0123, 1'b0, 1'b0);
    do_load(1, LH,  32'h000a, 64'h0, 64'h0123_4567_89ab_cdef, 0, 64'hffff_ffff_ffff_89ab, 1'b0, 1'b0);
    // LWR k=3: (D>>24) | (R & ffffff0000000000)
    do_load(1, LWR, 32'h0003, 64'hffee_ddcc_bbaa_9988, 64'h0123_4567_89ab_cdef, 2,
            64'hffee_dd01_2345_6789, 1'b0, 1'b0);
    do_load(1, LW,  32'h000c, 64'h0, 64'h0123_4567_89ab_cdef, 0, 64'h0, 1'b1, 1'b0);

    // Reset in the middle of a stalled read.
    @(negedge clk);
    funct = LH; addr = 32'h2002; stall_cfg = 10; rdata_cfg = 64'hc84d_1234;
    e.res = 64'h0; e.err = 1'b0; e.start_cyc = cyc; e.lat = 0; e.reads = 0; e.maddr = 32'h2000;
    sb32.push_back(e);
    $display("[TB] dut32 funct=%b addr=%h stalls=10 -> reset during read, expect no done", funct, addr);
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    check("pre_rst_mem_read", 64'(bus32.mem_read), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_mem_read", 64'(bus32.mem_read), 64'd0);
    check("mid_rst_busy", 64'(busy32), 64'd0);
    check("mid_rst_done", 64'(done32), 64'd0);
    check("mid_rst_result", 64'(res32), 64'd0);
    #1;
    sb32.delete();
    rd_cnt[0] = 0;
    last_res[0] = '0;
    last_res[1] = '0;
    repeat (12) @(negedge clk);

    // After reset the unit works again; an error leaves the cleared result.
    do_load(0, LH, 32'h2001, 64'h0, 64'h0, 0, 64'h0, 1'b1, 1'b0);
    do_load(0, LHU, 32'h2002, 64'h0, 64'hc84d_1234, 0, 64'h0000_c84d, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
